// File: rtl/lab9_soc_pio_edge.sv
// Avalon-MM PIO with registered output port, synchronized input port,
// per-bit edge capture and a maskable level interrupt.
module lab9_soc_pio_edge #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] PRIME_END = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] sync_d_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_w, clr_w, wdat, rd_w;
  logic [2:0]       prime_q, prime_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             primed, wr;
  logic             unused_wd;

  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign wdat      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign wr        = chipselect & ~write_n;
  assign primed    = (prime_q == PRIME_END);

  // Edges are ignored until the synchronizer chain has flushed reset zeros.
  always_comb begin
    edge_w = '0;
    if (primed) begin
      unique case (EDGE_TYPE)
        0:       edge_w = sync_in & ~sync_d_q;
        1:       edge_w = ~sync_in & sync_d_q;
        default: edge_w = sync_in ^ sync_d_q;
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    clr_w  = '0;
    if (wr) begin
      unique case (address)
        3'd0, 3'd1: data_d = wdat;
        3'd2:       mask_d = wdat;
        3'd3:       clr_w  = wdat;
        3'd4:       data_d = data_q | wdat;
        3'd5:       data_d = data_q & ~wdat;
        default:    ;
      endcase
    end
    // A new edge overrides a simultaneous clear of the same bit.
    cap_d   = (cap_q & ~clr_w) | edge_w;
    prime_d = primed ? prime_q : prime_q + 3'd1;
  end

  always_comb begin
    rd_w = '0;
    unique case (address)
      3'd0:    rd_w = sync_in;
      3'd1:    rd_w = data_q;
      3'd2:    rd_w = mask_q;
      3'd3:    rd_w = cap_q;
      default: rd_w = '0;
    endcase
    rdata_d = 32'(rd_w);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sync_d_q <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sync_d_q <= sync_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE[WIDTH-1:0];
      mask_q  <= '0;
      cap_q   <= '0;
      prime_q <= '0;
      rdata_q <= '0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      cap_q   <= cap_d;
      prime_q <= prime_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = data_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_lab9_soc_pio_edge.sv
// Directed bench for lab9_soc_pio_edge; read results are checked
// through a queue of expected readdata values.
module tb_lab9_soc_pio_edge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] in_port;
  logic [15:0] out_port;
  logic        irq;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  lab9_soc_pio_edge #(
    .WIDTH(16), .RESET_VALUE(32'h0), .EDGE_TYPE(0), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .out_port(out_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [2:0] a,
                    input logic [31:0] e);
    logic [31:0] x;
    address = a;
    exp_q.push_back(e);
    tick();
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      x = exp_q.pop_front();
      chk(tag, readdata, x);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 16'hFFFF;
    #2;
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;

    // inputs high through reset release must not capture
    ticks(10);
    chk("prime_irq", 32'(irq), 32'h0);
    rd("prime_cap", 3'd3, 32'h0);
    rd("sync_in", 3'd0, 32'h0000FFFF);

    wr(3'd0, 32'h1234);
    chk("out_wr0", 32'(out_port), 32'h1234);
    wr(3'd4, 32'h00F0);
    chk("out_set", 32'(out_port), 32'h12F4);
    wr(3'd5, 32'h0204);
    chk("out_clr", 32'(out_port), 32'h10F0);
    rd("rd_data", 3'd1, 32'h000010F0);

    wr(3'd2, 32'hFFFFFFFF);
    rd("rd_mask", 3'd2, 32'h0000FFFF);
    rd("rd_a6", 3'd6, 32'h0);
    rd("rd_a4", 3'd4, 32'h0);
    wr(3'd2, 32'h0001);

    // falling edges must not capture with EDGE_TYPE rising
    in_port = 16'h0000;
    ticks(5);
    rd("fall_cap", 3'd3, 32'h0);

    in_port = 16'h0001;
    tick();
    chk("edge_t1", 32'(irq), 32'h0);
    tick();
    chk("edge_t2", 32'(irq), 32'h0);
    tick();
    chk("edge_t3", 32'(irq), 32'h1);
    rd("cap_b0", 3'd3, 32'h1);
    wr(3'd3, 32'h0001);
    chk("clr_irq", 32'(irq), 32'h0);
    rd("cap_clr", 3'd3, 32'h0);

    // bit3 edge lands in the same cycle as its clear
    in_port = 16'h0009;
    ticks(2);
    wr(3'd3, 32'h0008);
    rd("set_wins", 3'd3, 32'h8);
    chk("mask_gate", 32'(irq), 32'h0);
    wr(3'd3, 32'h0008);
    rd("cap_clr3", 3'd3, 32'h0);

    in_port = 16'h0000;
    ticks(4);
    wr(3'd3, 32'hFFFF);
    in_port = 16'h0001;
    ticks(3);
    chk("irq_on", 32'(irq), 32'h1);
    wr(3'd2, 32'h0);
    chk("mask_off", 32'(irq), 32'h0);
    rd("cap_kept", 3'd3, 32'h1);

    wr(3'd0, 32'hABCD);
    wr(3'd2, 32'h0001);
    chk("pre_out", 32'(out_port), 32'hABCD);
    chk("pre_irq", 32'(irq), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_out", 32'(out_port), 32'h0);
    chk("ar_irq", 32'(irq), 32'h0);
    chk("ar_rdata", readdata, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1;
    ticks(10);
    rd("ar_cap", 3'd3, 32'h0);
    rd("ar_mask", 3'd2, 32'h0);
    chk("ar_irq2", 32'(irq), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
